// File: rtl/commit_alloc_pkg.sv
// Shared definitions for the commit-station allocator: default sizing and FSM states.
package commit_alloc_pkg;

  localparam int unsigned NCOMMIT_DEF  = 32;
  localparam int unsigned LNCOMMIT_DEF = 5;
  localparam int unsigned NDEC_DEF     = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RELOAD1 = 2'd1,
    RELOAD2 = 2'd2
  } commit_state_e;

endpackage

// File: rtl/commit_window_check.sv
// Combinational test of whether addr lies in the circular live window [head, tail).
module commit_window_check
  import commit_alloc_pkg::*;
#(
  parameter int unsigned LNCOMMIT = LNCOMMIT_DEF
) (
  input  logic [LNCOMMIT-1:0] addr,
  input  logic [LNCOMMIT-1:0] head,
  input  logic [LNCOMMIT-1:0] tail,
  input  logic                full,
  output logic                in_window
);

  // head==tail is ambiguous, so the full flag selects "everything" over "nothing"
  always_comb begin
    in_window = 1'b0;
    if (full) begin
      in_window = 1'b1;
    end else if (head <= tail) begin
      in_window = (addr >= head) && (addr < tail);
    end else begin
      in_window = (addr >= head) || (addr < tail);
    end
  end

endmodule

// File: rtl/commit_alloc.sv
// Circular commit-station allocator with retire, branch/trap recovery and a two-cycle reload bubble.
module commit_alloc
  import commit_alloc_pkg::*;
#(
  parameter int unsigned NCOMMIT  = NCOMMIT_DEF,
  parameter int unsigned LNCOMMIT = LNCOMMIT_DEF,
  parameter int unsigned NDEC     = NDEC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LNCOMMIT-1:0] alloc_count,
  input  logic [LNCOMMIT:0]   retire_count,
  input  logic                br_flush,
  input  logic [LNCOMMIT-1:0] br_flush_addr,
  input  logic                trap_flush,
  output logic                alloc_ack,
  output logic [LNCOMMIT-1:0] next_start,
  output logic [LNCOMMIT-1:0] current_end,
  output logic [LNCOMMIT:0]   current_available,
  output logic                reloading,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PW = LNCOMMIT;
  localparam int unsigned CW = LNCOMMIT + 1;
  localparam int unsigned SW = LNCOMMIT + 2;

  commit_state_e state_q, state_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_ret;
  logic [CW-1:0] count_q, count_d, count_ret, ret_eff, br_dist;
  logic          flush, br_hit;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(p) + SW'(n);
    if (s >= SW'(NCOMMIT)) s = s - SW'(NCOMMIT);
    return PW'(s);
  endfunction

  assign flush = trap_flush | br_flush;

  // Retire always applies first; an over-large retire is clamped to the live count
  always_comb begin
    ret_eff   = (retire_count > count_q) ? count_q : retire_count;
    head_ret  = ptr_add(head_q, ret_eff);
    count_ret = count_q - ret_eff;
    if (br_flush_addr >= head_ret) begin
      br_dist = CW'(br_flush_addr) - CW'(head_ret);
    end else begin
      br_dist = CW'(br_flush_addr) + CW'(NCOMMIT) - CW'(head_ret);
    end
  end

  commit_window_check #(.LNCOMMIT(LNCOMMIT)) u_window (
    .addr      (br_flush_addr),
    .head      (head_ret),
    .tail      (tail_q),
    .full      (count_ret == CW'(NCOMMIT)),
    .in_window (br_hit)
  );

  assign next_start        = tail_q;
  assign current_end       = head_q;
  assign current_available = CW'(NCOMMIT) - count_q;
  assign full              = (count_q == CW'(NCOMMIT));
  assign empty             = (count_q == '0);

  always_comb begin
    head_d  = head_ret;
    tail_d  = tail_q;
    count_d = count_ret;
    if (trap_flush) begin
      tail_d  = head_ret;
      count_d = '0;
    end else if (br_flush) begin
      if (br_hit) begin
        tail_d  = ptr_add(br_flush_addr, CW'(1));
        count_d = br_dist + CW'(1);
      end else begin
        tail_d  = head_ret;
        count_d = '0;
      end
    end else if (alloc_ack) begin
      tail_d  = ptr_add(tail_q, CW'(alloc_count));
      count_d = count_ret + CW'(alloc_count);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RELOAD1;
    end else begin
      case (state_q)
        RUN:     state_d = RUN;
        RELOAD1: state_d = RELOAD2;
        RELOAD2: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // reset gates the grant so outputs sit at their idle values while reset is held
  always_comb begin
    reloading = (state_q != RUN);
    alloc_ack = reset && (state_q == RUN) && !flush && (alloc_count != '0) &&
                (CW'(alloc_count) <= current_available);
  end

  a_retire_legal: assert property (@(posedge clk) disable iff (!reset)
    retire_count <= count_q);
  a_alloc_width: assert property (@(posedge clk) disable iff (!reset)
    CW'(alloc_count) <= CW'(2 * NDEC));

endmodule

// File: tb/tb_commit_alloc.sv
// Directed scoreboard bench for commit_alloc.
module tb_commit_alloc;

  typedef struct {
    string      nm;
    logic       ack;
    logic [4:0] ns;
    logic [4:0] ce;
    logic [5:0] av;
    logic       rel;
    logic       full;
    logic       empty;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] alloc_count = '0;
  logic [5:0] retire_count = '0;
  logic       br_flush = 1'b0;
  logic [4:0] br_flush_addr = '0;
  logic       trap_flush = 1'b0;
  logic       alloc_ack, reloading, full, empty;
  logic [4:0] next_start, current_end;
  logic [5:0] current_available;
  logic       mon_kick = 1'b0;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  commit_alloc dut (
    .clk               (clk),
    .reset             (reset),
    .alloc_count       (alloc_count),
    .retire_count      (retire_count),
    .br_flush          (br_flush),
    .br_flush_addr     (br_flush_addr),
    .trap_flush        (trap_flush),
    .alloc_ack         (alloc_ack),
    .next_start        (next_start),
    .current_end       (current_end),
    .current_available (current_available),
    .reloading         (reloading),
    .full              (full),
    .empty             (empty)
  );

  always #5 clk = ~clk;

  always @(negedge clk or posedge mon_kick) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (alloc_ack !== e.ack || next_start !== e.ns || current_end !== e.ce ||
          current_available !== e.av || reloading !== e.rel || full !== e.full ||
          empty !== e.empty) begin
        errors++;
        $display("FAIL %s: got ack=%0b ns=%0d ce=%0d av=%0d rel=%0b full=%0b empty=%0b; expected ack=%0b ns=%0d ce=%0d av=%0d rel=%0b full=%0b empty=%0b",
                 e.nm, alloc_ack, next_start, current_end, current_available, reloading, full, empty,
                 e.ack, e.ns, e.ce, e.av, e.rel, e.full, e.empty);
      end
    end
  end

  task automatic drive(input int a, input int r, input bit bf, input int ba, input bit tf);
    alloc_count   = 5'(a);
    retire_count  = 6'(r);
    br_flush      = bf;
    br_flush_addr = 5'(ba);
    trap_flush    = tf;
  endtask

  task automatic expect_out(input string nm, input bit ack, input int ns, input int ce,
                            input int av, input bit rel);
    exp_t x;
    x.nm = nm; x.ack = ack; x.ns = 5'(ns); x.ce = 5'(ce); x.av = 6'(av); x.rel = rel;
    x.full = (av == 0);
    x.empty = (av == 32);
    sb.push_back(x);
  endtask

  // Drive one cycle's inputs, queue the expected outputs, advance past the next edge
  task automatic cyc(input string nm, input int a, input int r, input bit bf, input int ba,
                     input bit tf, input bit ack, input int ns, input int ce, input int av,
                     input bit rel);
    drive(a, r, bf, ba, tf);
    expect_out(nm, ack, ns, ce, av, rel);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_idle",  8, 0, 0, 0, 0,  0, 0, 0, 32, 0);
    reset = 1'b1;
    // fill the ring in four grants of eight
    cyc("fill0",       8, 0, 0, 0, 0,  1, 0, 0, 32, 0);
    cyc("fill1",       8, 0, 0, 0, 0,  1, 8, 0, 24, 0);
    cyc("fill2",       8, 0, 0, 0, 0,  1, 16, 0, 16, 0);
    cyc("fill3",       8, 0, 0, 0, 0,  1, 24, 0, 8, 0);
    cyc("full_reject", 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    // wrap with simultaneous alloc and retire
    cyc("ret28",       0, 28, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("alloc4",      4, 0, 0, 0, 0,  1, 0, 28, 28, 0);
    cyc("alloc_ret",   4, 3, 0, 0, 0,  1, 4, 28, 24, 0);
    cyc("after_wrap",  0, 9, 0, 0, 0,  0, 8, 31, 23, 0);
    cyc("w1",          8, 0, 0, 0, 0,  1, 8, 8, 32, 0);
    cyc("w2",          8, 8, 0, 0, 0,  1, 16, 8, 24, 0);
    cyc("w3",          8, 8, 0, 0, 0,  1, 24, 16, 24, 0);
    cyc("w4",          8, 8, 0, 0, 0,  1, 0, 24, 24, 0);
    cyc("w5",          6, 2, 0, 0, 0,  1, 8, 0, 24, 0);
    cyc("w6",          6, 0, 0, 0, 0,  1, 14, 2, 20, 0);
    // branch flush inside window, then bubble
    cyc("brf9",        4, 0, 1, 9, 0,  0, 20, 2, 14, 0);
    cyc("bubble1",     4, 0, 0, 0, 0,  0, 10, 2, 24, 1);
    cyc("bubble2",     4, 0, 0, 0, 0,  0, 10, 2, 24, 1);
    cyc("run_again",   4, 0, 0, 0, 0,  1, 10, 2, 24, 0);
    // branch flush whose target is retired on the same edge
    cyc("brf_ret",     0, 10, 1, 9, 0, 0, 14, 2, 20, 0);
    cyc("brf_empty",   0, 0, 0, 0, 0,  0, 12, 12, 32, 1);
    cyc("brf_rl2",     0, 0, 0, 0, 0,  0, 12, 12, 32, 1);
    cyc("b1",          8, 0, 0, 0, 0,  1, 12, 12, 32, 0);
    cyc("b2",          8, 0, 0, 0, 0,  1, 20, 12, 24, 0);
    cyc("brf15",       0, 0, 1, 15, 0, 0, 28, 12, 16, 0);
    cyc("brf15_rl1",   0, 0, 0, 0, 0,  0, 16, 12, 28, 1);
    // trap during RELOAD2 restarts the bubble
    cyc("trap_rl2",    2, 1, 0, 0, 1,  0, 16, 12, 28, 1);
    cyc("trap_rl1",    2, 0, 0, 0, 0,  0, 13, 13, 32, 1);
    cyc("trap_rl2b",   2, 0, 0, 0, 0,  0, 13, 13, 32, 1);
    cyc("c1",          8, 0, 0, 0, 0,  1, 13, 13, 32, 0);
    cyc("c2",          8, 0, 0, 0, 0,  1, 21, 13, 24, 0);
    cyc("c3",          1, 0, 0, 0, 0,  1, 29, 13, 16, 0);
    cyc("brf29",       0, 0, 1, 29, 0, 0, 30, 13, 15, 0);
    // reset mid-reload, observed before any clock edge
    drive(8, 0, 0, 0, 0);
    expect_out("rl1_cnt17", 0, 30, 13, 15, 1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    expect_out("async_reset", 0, 0, 0, 32, 0);
    #1 mon_kick = 1'b1;
    #1 mon_kick = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset_hold",  8, 0, 0, 0, 0,  0, 0, 0, 32, 0);
    reset = 1'b1;
    cyc("post_reset",  3, 0, 0, 0, 0,  1, 0, 0, 32, 0);
    cyc("post_idle",   0, 0, 0, 0, 0,  0, 3, 0, 29, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
